mem_feedback_tracker: RTL and testbench

Scoreboard-side receiver for memory-unit completion feedback. It records every memory instruction issued to the memory unit by warp and scoreboard slot, together with its active-thread mask. It consumes positive feedback (thread completion) and negative feedback (MSHR miss / retry) and presents replay requests back to the issue logic. It pulses a release when all threads of an instruction have completed, which frees the scoreboard slot.

---
 rtl/mem_feedback_tracker.sv | 147 ++++++++++++++
 tb/tb_mem_feedback_tracker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_feedback_tracker.sv
// Tracks memory instructions per {warp, scoreboard slot} until every active thread completes,
// turning MSHR-miss feedback into replay requests and emitting a release pulse per finished entry.
module mem_feedback_tracker #(
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned NUM_SCB   = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      issue_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]              issue_warp,
  input  logic [$clog2(NUM_SCB)-1:0]                issue_scb,
  input  logic [7:0]                                issue_pam,
  input  logic                                      neg_fb_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]              neg_fb_warp,
  input  logic [$clog2(NUM_SCB)-1:0]                neg_fb_scb,
  input  logic                                      pos_fb_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]              pos_fb_warp,
  input  logic [$clog2(NUM_SCB)-1:0]                pos_fb_scb,
  input  logic [7:0]                                pos_fb_mask,
  output logic                                      replay_valid,
  output logic [$clog2(NUM_WARPS)-1:0]              replay_warp,
  output logic [$clog2(NUM_SCB)-1:0]                replay_scb,
  output logic [7:0]                                replay_mask,
  input  logic                                      replay_ready,
  output logic                                      release_valid,
  output logic [$clog2(NUM_WARPS)-1:0]              release_warp,
  output logic [$clog2(NUM_SCB)-1:0]                release_scb,
  output logic [NUM_WARPS-1:0]                      warp_busy,
  output logic [$clog2(NUM_WARPS*NUM_SCB+1)-1:0]    outstanding,
  output logic                                      err
);

  localparam int unsigned Entries = NUM_WARPS * NUM_SCB;
  localparam int unsigned SW      = $clog2(NUM_SCB);
  localparam int unsigned IW      = $clog2(NUM_WARPS) + SW;
  localparam int unsigned CntW    = $clog2(Entries + 1);

  typedef enum logic [1:0] {StFree, StPending, StReplay} entry_st_e;

  entry_st_e         state_q [Entries];
  entry_st_e         state_d [Entries];
  logic [7:0]        rem_q   [Entries];
  logic [7:0]        rem_d   [Entries];
  logic              err_q, err_d;
  logic              rel_q, rel_d;
  logic [IW-1:0]     rel_idx_q, rel_idx_d;

  logic              rep_any;
  logic [IW-1:0]     rep_idx;
  logic [Entries-1:0] iss_hit, pos_hit, neg_hit, gnt_hit;

  // Fixed priority: the descending scan leaves the lowest REPLAY index selected.
  always_comb begin
    rep_any = 1'b0;
    rep_idx = '0;
    for (int i = Entries - 1; i >= 0; i--) begin
      if (state_q[i] == StReplay) begin
        rep_any = 1'b1;
        rep_idx = IW'(i);
      end
    end
  end

  assign replay_valid = rep_any;
  assign replay_warp  = rep_any ? rep_idx[IW-1:SW] : '0;
  assign replay_scb   = rep_any ? rep_idx[SW-1:0] : '0;
  assign replay_mask  = rep_any ? rem_q[rep_idx] : '0;

  assign iss_hit = issue_valid  ? (Entries'(1) << {issue_warp, issue_scb})   : '0;
  assign pos_hit = pos_fb_valid ? (Entries'(1) << {pos_fb_warp, pos_fb_scb}) : '0;
  assign neg_hit = neg_fb_valid ? (Entries'(1) << {neg_fb_warp, neg_fb_scb}) : '0;
  assign gnt_hit = (rep_any && replay_ready) ? (Entries'(1) << rep_idx) : '0;

  always_comb begin
    err_d     = err_q;
    rel_d     = 1'b0;
    rel_idx_d = rel_idx_q;
    for (int i = 0; i < Entries; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      if (state_q[i] == StFree) begin
        if (pos_hit[i] || neg_hit[i]) err_d = 1'b1;
        if (iss_hit[i]) begin
          if (issue_pam == 8'h00) begin
            err_d = 1'b1;
          end else begin
            state_d[i] = StPending;
            rem_d[i]   = issue_pam;
          end
        end
      end else begin
        // Live entry, even one emptied this cycle, rejects a new issue.
        if (iss_hit[i]) err_d = 1'b1;
        if (pos_hit[i]) begin
          if ((pos_fb_mask & ~rem_q[i]) != 8'h00) err_d = 1'b1;
          rem_d[i] = rem_q[i] & ~pos_fb_mask;
        end
        if (pos_hit[i] && (rem_d[i] == 8'h00)) begin
          state_d[i] = StFree;
          rel_d      = 1'b1;
          rel_idx_d  = IW'(i);
        end else if (neg_hit[i]) begin
          state_d[i] = StReplay;
        end else if (gnt_hit[i]) begin
          state_d[i] = StPending;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Entries; i++) begin
        state_q[i] <= StFree;
        rem_q[i]   <= 8'h00;
      end
      err_q     <= 1'b0;
      rel_q     <= 1'b0;
      rel_idx_q <= '0;
    end else begin
      for (int i = 0; i < Entries; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
      err_q     <= err_d;
      rel_q     <= rel_d;
      rel_idx_q <= rel_idx_d;
    end
  end

  always_comb begin
    warp_busy   = '0;
    outstanding = '0;
    for (int i = 0; i < Entries; i++) begin
      if (state_q[i] != StFree) begin
        warp_busy[i / NUM_SCB] = 1'b1;
        outstanding            = outstanding + CntW'(1);
      end
    end
  end

  assign release_valid = rel_q;
  assign release_warp  = rel_idx_q[IW-1:SW];
  assign release_scb   = rel_idx_q[SW-1:0];
  assign err           = err_q;

endmodule

// File: tb/tb_mem_feedback_tracker.sv
// Randomized bench for mem_feedback_tracker against an event-level reference model,
// plus directed scenarios for completion, replay, arbitration, collisions, errors and reset.
module tb_mem_feedback_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, neg_fb_valid, pos_fb_valid, replay_ready;
  logic [2:0] issue_warp, neg_fb_warp, pos_fb_warp;
  logic [1:0] issue_scb, neg_fb_scb, pos_fb_scb;
  logic [7:0] issue_pam, pos_fb_mask;
  logic       replay_valid, release_valid, err;
  logic [2:0] replay_warp, release_warp;
  logic [1:0] replay_scb, release_scb;
  logic [7:0] replay_mask, warp_busy;
  logic [5:0] outstanding;

  mem_feedback_tracker dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_warp(issue_warp), .issue_scb(issue_scb),
    .issue_pam(issue_pam),
    .neg_fb_valid(neg_fb_valid), .neg_fb_warp(neg_fb_warp), .neg_fb_scb(neg_fb_scb),
    .pos_fb_valid(pos_fb_valid), .pos_fb_warp(pos_fb_warp), .pos_fb_scb(pos_fb_scb),
    .pos_fb_mask(pos_fb_mask),
    .replay_valid(replay_valid), .replay_warp(replay_warp), .replay_scb(replay_scb),
    .replay_mask(replay_mask), .replay_ready(replay_ready),
    .release_valid(release_valid), .release_warp(release_warp), .release_scb(release_scb),
    .warp_busy(warp_busy), .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: 0 = free, 1 = pending, 2 = replay
  int         mst  [32];
  logic [7:0] mrem [32];
  bit         mrel_v;
  int         mrel_idx;
  bit         merr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < 32; i++) begin
      mst[i]  = 0;
      mrem[i] = 8'h00;
    end
    mrel_v   = 0;
    mrel_idx = 0;
    merr     = 0;
  endtask

  task automatic check_all(input string tag);
    int   sel = -1;
    int   cnt = 0;
    logic [7:0] busy = 8'h00;
    for (int i = 31; i >= 0; i--) if (mst[i] == 2) sel = i;
    for (int i = 0; i < 32; i++) if (mst[i] != 0) begin
      cnt++;
      busy[i / 4] = 1'b1;
    end
    check_eq({tag, ".rv"},   replay_valid, sel >= 0);
    check_eq({tag, ".rw"},   replay_warp,  sel >= 0 ? sel / 4 : 0);
    check_eq({tag, ".rs"},   replay_scb,   sel >= 0 ? sel % 4 : 0);
    check_eq({tag, ".rm"},   replay_mask,  sel >= 0 ? mrem[sel] : 0);
    check_eq({tag, ".relv"}, release_valid, mrel_v);
    check_eq({tag, ".relw"}, release_warp, mrel_idx / 4);
    check_eq({tag, ".rels"}, release_scb,  mrel_idx % 4);
    check_eq({tag, ".busy"}, warp_busy,    busy);
    check_eq({tag, ".out"},  outstanding,  cnt);
    check_eq({tag, ".err"},  err,          merr);
  endtask

  // Applies this cycle's inputs to the model the way the behaviour is described in prose.
  task automatic model_step;
    int         ns [32];
    logic [7:0] nr [32];
    int  g = -1;
    bit  freed = 0;
    int  p = int'({pos_fb_warp, pos_fb_scb});
    int  n = int'({neg_fb_warp, neg_fb_scb});
    int  k = int'({issue_warp, issue_scb});
    ns = mst;
    nr = mrem;
    if (replay_ready) for (int i = 31; i >= 0; i--) if (mst[i] == 2) g = i;
    if (pos_fb_valid) begin
      if (mst[p] == 0) merr = 1;
      else begin
        if ((pos_fb_mask & ~mrem[p]) != 0) merr = 1;
        nr[p] = mrem[p] & ~pos_fb_mask;
        if (nr[p] == 0) begin
          ns[p] = 0;
          freed = 1;
          mrel_idx = p;
        end
      end
    end
    if (neg_fb_valid) begin
      if (mst[n] == 0) merr = 1;
      else if (!(freed && p == n)) ns[n] = 2;
    end
    if (g >= 0 && !(freed && p == g) && !(neg_fb_valid && n == g)) ns[g] = 1;
    if (issue_valid) begin
      if (mst[k] != 0 || issue_pam == 0) merr = 1;
      else begin
        ns[k] = 1;
        nr[k] = issue_pam;
      end
    end
    mrel_v = freed;
    mst    = ns;
    mrem   = nr;
  endtask

  task automatic clear_in;
    issue_valid = 0; issue_warp = 0; issue_scb = 0; issue_pam = 0;
    neg_fb_valid = 0; neg_fb_warp = 0; neg_fb_scb = 0;
    pos_fb_valid = 0; pos_fb_warp = 0; pos_fb_scb = 0; pos_fb_mask = 0;
    replay_ready = 0;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    clear_in();
  endtask

  task automatic do_reset;
    clear_in();
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("rst");
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic set_iss(input int idx, input logic [7:0] pam);
    issue_valid = 1; {issue_warp, issue_scb} = 5'(idx); issue_pam = pam;
  endtask
  task automatic set_pos(input int idx, input logic [7:0] m);
    pos_fb_valid = 1; {pos_fb_warp, pos_fb_scb} = 5'(idx); pos_fb_mask = m;
  endtask
  task automatic set_neg(input int idx);
    neg_fb_valid = 1; {neg_fb_warp, neg_fb_scb} = 5'(idx);
  endtask

  function automatic int pick_live();
    int s = int'($urandom_range(0, 31));
    for (int j = 0; j < 32; j++) if (mst[(s + j) % 32] != 0) return (s + j) % 32;
    return s;
  endfunction

  initial begin
    clear_in();
    rst = 1'b0;
    model_reset();
    #3 check_all("init");
    @(negedge clk) rst = 1'b1;

    // Basic completion w3/s1
    set_iss(13, 8'hFF);  step("b_iss");
    check_eq("b_out1", outstanding, 1);
    check_eq("b_busy1", warp_busy, 8'h08);
    set_pos(13, 8'h0F);  step("b_p1");
    set_pos(13, 8'hF0);  step("b_p2");
    check_eq("b_rel", {release_valid, release_warp, release_scb}, {1'b1, 3'd3, 2'd1});
    check_eq("b_out0", outstanding, 0);
    step("b_idle");
    check_eq("b_relpulse", release_valid, 0);

    // Replay w2/s0
    set_iss(8, 8'h3C);   step("r_iss");
    set_neg(8);          step("r_neg");
    check_eq("r_mask", {replay_valid, replay_mask}, {1'b1, 8'h3C});
    set_pos(8, 8'h0C);   step("r_p1");
    replay_ready = 1;    step("r_gnt");
    check_eq("r_gnt_v", replay_valid, 0);
    set_pos(8, 8'h30);   step("r_p2");
    check_eq("r_rel", release_valid, 1);

    // Simultaneous pos+neg
    set_iss(16, 8'h01);  step("s_iss1");
    set_pos(16, 8'h01); set_neg(16); step("s_pn1");
    check_eq("s_rel1", {release_valid, replay_valid, err}, 3'b100);
    set_iss(17, 8'h03);  step("s_iss2");
    set_pos(17, 8'h01); set_neg(17); step("s_pn2");
    check_eq("s_rep2", {replay_valid, replay_mask}, {1'b1, 8'h02});
    replay_ready = 1;    step("s_gnt");
    set_pos(17, 8'h02);  step("s_p");

    // Arbitration w5/s2 vs w1/s3
    set_iss(22, 8'h0F);  step("a_iss1");
    set_iss(7, 8'hF0);   step("a_iss2");
    set_neg(22);         step("a_neg1");
    set_neg(7);          step("a_neg2");
    check_eq("a_first", {replay_warp, replay_scb}, {3'd1, 2'd3});
    replay_ready = 1;    step("a_gnt1");
    check_eq("a_second", {replay_warp, replay_scb}, {3'd5, 2'd2});
    replay_ready = 1;    step("a_gnt2");
    set_pos(22, 8'h0F);  step("a_p1");
    set_pos(7, 8'hF0);   step("a_p2");

    // Errors
    set_iss(0, 8'h11);   step("e_iss1");
    set_iss(0, 8'h22);   step("e_iss2");
    check_eq("e_err", err, 1);
    set_pos(31, 8'h01);  step("e_pfree");
    check_eq("e_sticky", {err, outstanding}, {1'b1, 6'd1});
    set_pos(0, 8'h11);   step("e_clean");

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 1)
        set_iss(int'($urandom_range(0, 31)),
                ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        int t = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 31)) : pick_live();
        set_pos(t, ($urandom_range(0, 15) == 0) ? 8'($urandom) : (mrem[t] & 8'($urandom)));
        if ($urandom_range(0, 3) == 0) set_neg(t);
      end
      if ($urandom_range(0, 3) == 0)
        set_neg(($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 31)) : pick_live());
      replay_ready = 1'($urandom);
      step("rnd");
      if (c % 500 == 499) do_reset();
    end

    // Fill all entries, then reset asynchronously
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_iss(i, 8'hFF);
      step("f_iss");
    end
    check_eq("f_out32", {outstanding, warp_busy}, {6'd32, 8'hFF});
    #2 rst = 1'b0;
    #1 model_reset();
    check_eq("f_rst_out", outstanding, 0);
    check_eq("f_rst_busy", warp_busy, 0);
    check_all("f_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
